// File: rtl/reaction_pkg.sv
// Shared state/mode encodings and the lowest-index priority helper for the reaction game.
package reaction_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_ARMED = 2'd1;
    localparam logic [1:0] MODE_GO    = 2'd2;
    localparam logic [1:0] MODE_DONE  = 2'd3;

    // State codes equal the mode codes so the state register drives `mode` directly.
    typedef enum logic [1:0] {
        ST_IDLE  = MODE_IDLE,
        ST_ARMED = MODE_ARMED,
        ST_GO    = MODE_GO,
        ST_DONE  = MODE_DONE
    } state_e;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reaction_core_tick_gen.sv
// Timer tick divider: one-cycle `tick` every DIV clocks; `clr` restarts the count from zero.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reaction_core.sv
// Reaction-game engine: N player buttons, LFSR-randomised arming delay, tick-based reaction timer.
// Define REACTION_BEST_TIME_EN to build the best-time register; the LFSR port is rand_val (rand is reserved).
module reaction_core
    import reaction_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 1000,
    parameter int N_PLAYERS   = 4,
    parameter int TIME_W      = 14,
    parameter int MAX_TIME    = 9999,
    parameter int RAND_W      = 14,
    parameter int DELAY_MIN   = 1000,
    parameter int DELAY_RND_W = 12,
    localparam int WIN_W      = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start,
    input  logic [N_PLAYERS-1:0] btn_player,
    input  logic [RAND_W-1:0]    rand_val,
    output logic [TIME_W-1:0]    number,
    output logic [1:0]           mode,
    output logic [WIN_W-1:0]     winner,
    output logic                 winner_vld,
    output logic                 foul,
    output logic                 timeout,
    output logic                 go_led,
    output logic [TIME_W-1:0]    best_time
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DLY_W = $clog2(DELAY_MIN + (1 << DELAY_RND_W));

    state_e               state_q, state_d;
    logic [DLY_W-1:0]     delay_q, delay_d, arm_delay;
    logic [TIME_W-1:0]    number_q, number_d;
    logic [WIN_W-1:0]     winner_q, winner_d, winner_idx;
    logic                 vld_q, vld_d, foul_q, foul_d, timeout_q, timeout_d, go_led_q, go_led_d;
    logic                 start_s_q, start_h_q;
    logic [N_PLAYERS-1:0] player_s_q, player_h_q;
    logic                 start_press, any_press, tick, tick_clr;
    logic [N_PLAYERS-1:0] player_press;
    logic                 unused_rand;

    assign start_press  = start_s_q & ~start_h_q;
    assign player_press = player_s_q & ~player_h_q;
    assign any_press    = |player_press;
    assign winner_idx   = WIN_W'(lowest_set(16'(player_press)));
    assign arm_delay    = DLY_W'(DELAY_MIN) + DLY_W'(rand_val[DELAY_RND_W-1:0]);
    assign unused_rand  = ^rand_val;

    // Restart the divider on every entry to ARMED or GO so the first tick lands DIV cycles later.
    assign tick_clr = (state_d != state_q) && (state_d == ST_ARMED || state_d == ST_GO);

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        number_d  = number_q;
        winner_d  = winner_q;
        vld_d     = vld_q;
        foul_d    = foul_q;
        timeout_d = timeout_q;
        go_led_d  = go_led_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_press) begin
                    state_d   = ST_ARMED;
                    delay_d   = arm_delay;
                    number_d  = '0;
                    winner_d  = '0;
                    vld_d     = 1'b0;
                    foul_d    = 1'b0;
                    timeout_d = 1'b0;
                    go_led_d  = 1'b0;
                end
            end
            ST_ARMED: begin
                if (any_press) begin
                    state_d  = ST_DONE;
                    foul_d   = 1'b1;
                    winner_d = winner_idx;
                    vld_d    = 1'b1;
                end else if (start_press) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (delay_q <= DLY_W'(1)) begin
                        state_d  = ST_GO;
                        go_led_d = 1'b1;
                        number_d = '0;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end
            end
            ST_GO: begin
                if (any_press) begin
                    state_d  = ST_DONE;
                    go_led_d = 1'b0;
                    winner_d = winner_idx;
                    vld_d    = 1'b1;
                end else if (start_press) begin
                    state_d  = ST_IDLE;
                    number_d = '0;
                    go_led_d = 1'b0;
                end else if (tick) begin
                    number_d = number_q + 1'b1;
                    if (number_q == TIME_W'(MAX_TIME - 1)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                        go_led_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    // History registers reset high so a button held through reset produces no edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            number_q   <= '0;
            winner_q   <= '0;
            vld_q      <= 1'b0;
            foul_q     <= 1'b0;
            timeout_q  <= 1'b0;
            go_led_q   <= 1'b0;
            start_s_q  <= 1'b1;
            start_h_q  <= 1'b1;
            player_s_q <= '1;
            player_h_q <= '1;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            number_q   <= number_d;
            winner_q   <= winner_d;
            vld_q      <= vld_d;
            foul_q     <= foul_d;
            timeout_q  <= timeout_d;
            go_led_q   <= go_led_d;
            start_s_q  <= btn_start;
            start_h_q  <= start_s_q;
            player_s_q <= btn_player;
            player_h_q <= player_s_q;
        end
    end

    assign mode       = state_q;
    assign number     = number_q;
    assign winner     = winner_q;
    assign winner_vld = vld_q;
    assign foul       = foul_q;
    assign timeout    = timeout_q;
    assign go_led     = go_led_q;

`ifdef REACTION_BEST_TIME_EN
    logic [TIME_W-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if (state_q == ST_GO && any_press && number_q < best_q) best_d = number_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) best_q <= TIME_W'(MAX_TIME);
        else      best_q <= best_d;
    end

    assign best_time = best_q;
`else
    assign best_time = '0;
`endif

endmodule

// File: tb/tb_reaction_core.sv
// Self-checking bench for reaction_core: elapsed-time reference model plus directed and random games.
module tb_reaction_core;

    localparam int DIV       = 10;
    localparam int MAX_TIME  = 20;
    localparam int DELAY_MIN = 3;
`ifdef REACTION_BEST_TIME_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic [3:0]  btn_player;
    logic [13:0] rand_val;
    logic [13:0] number;
    logic [1:0]  mode;
    logic [1:0]  winner;
    logic        winner_vld, foul, timeout, go_led;
    logic [13:0] best_time;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    reaction_core #(
        .CLK_HZ(1000), .TICK_HZ(100), .N_PLAYERS(4), .TIME_W(14), .MAX_TIME(MAX_TIME),
        .RAND_W(14), .DELAY_MIN(DELAY_MIN), .DELAY_RND_W(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_player(btn_player), .rand_val(rand_val),
        .number(number), .mode(mode), .winner(winner), .winner_vld(winner_vld), .foul(foul),
        .timeout(timeout), .go_led(go_led), .best_time(best_time)
    );

    always #5 clk = ~clk;

    // Reference model: tracks elapsed cycles in each phase rather than a tick counter.
    int m_mode, m_cyc, m_delay, m_number, m_winner, m_vld, m_foul, m_to, m_go, m_best;
    bit h1_s, h2_s;
    logic [3:0] h1_p, h2_p;
    bit ps;
    logic [3:0] pp;
    int c;

    function automatic int lowest(input logic [3:0] v);
        int idx;
        idx = 0;
        for (int i = 3; i >= 0; i--) if (v[i]) idx = i;
        return idx;
    endfunction

    function automatic int exp_best();
        return BEST_ON ? m_best : 0;
    endfunction

    task automatic m_clear();
        m_number = 0; m_winner = 0; m_vld = 0; m_foul = 0; m_to = 0; m_go = 0; m_cyc = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_delay = 0; m_best = MAX_TIME;
            m_clear();
            h1_s = 1'b1; h2_s = 1'b1; h1_p = '1; h2_p = '1;
        end else begin
            ps = h1_s & ~h2_s;
            pp = h1_p & ~h2_p;
            c  = m_cyc + 1;
            case (m_mode)
                0, 3: if (ps) begin
                    m_clear();
                    m_mode  = 1;
                    m_delay = DELAY_MIN + int'(rand_val[1:0]);
                end
                1: begin
                    if (pp != 0) begin
                        m_mode = 3; m_foul = 1; m_vld = 1; m_winner = lowest(pp);
                    end else if (ps) begin
                        m_mode = 0; m_clear();
                    end else if (c == m_delay * DIV) begin
                        m_mode = 2; m_go = 1; m_number = 0; m_cyc = 0;
                    end else m_cyc = c;
                end
                2: begin
                    if (pp != 0) begin
                        m_mode = 3; m_go = 0; m_vld = 1; m_winner = lowest(pp);
                        if (m_number < m_best) m_best = m_number;
                    end else if (ps) begin
                        m_mode = 0; m_clear();
                    end else begin
                        m_cyc = c;
                        if (c % DIV == 0) begin
                            if (c / DIV >= MAX_TIME) begin
                                m_number = MAX_TIME; m_mode = 3; m_to = 1; m_go = 0;
                            end else m_number = c / DIV;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
            h2_s = h1_s; h1_s = btn_start;
            h2_p = h1_p; h1_p = btn_player;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mode",       int'(mode),       m_mode);
            chk("number",     int'(number),     m_number);
            chk("winner",     int'(winner),     m_winner);
            chk("winner_vld", int'(winner_vld), m_vld);
            chk("foul",       int'(foul),       m_foul);
            chk("timeout",    int'(timeout),    m_to);
            chk("go_led",     int'(go_led),     m_go);
            chk("best_time",  int'(best_time),  exp_best());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        btn_start = 1'b1; @(negedge clk); btn_start = 1'b0; @(negedge clk);
    endtask

    task automatic pulse_player(input logic [3:0] mask);
        btn_player = mask; @(negedge clk); btn_player = 4'b0000; @(negedge clk);
    endtask

    task automatic wait_mode(input int m, input int max_cyc, output int k);
        k = 0;
        while (int'(mode) != m && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("wait_mode%0d", m), int'(mode), m);
    endtask

    task automatic play(input int r, input int t, input logic [3:0] mask, output int k);
        rand_val = 14'(r);
        pulse_start();
        chk("armed_mode", int'(mode), 1);
        wait_mode(2, 100, k);
        cyc(t * DIV + 2);
        pulse_player(mask);
    endtask

    initial begin
        int k;
        int p;
        btn_start = 1'b0; btn_player = 4'b0000; rand_val = '0; rst = 1'b1;
        #3 rst = 1'b0; cmp_en = 1'b1;
        #1;
        chk("reset_mode", int'(mode), 0);
        chk("reset_number", int'(number), 0);
        chk("reset_best", int'(best_time), BEST_ON ? MAX_TIME : 0);
        cyc(3); rst = 1'b1; cyc(2);

        // Best-time sequence: wins of 9, 6, 8 ticks.
        play(1, 9, 4'b0001, k);
        chk("win9_number", int'(number), 9);
        chk("win9_best", int'(best_time), BEST_ON ? 9 : 0);
        play(0, 6, 4'b1000, k);
        chk("win6_winner", int'(winner), 3);
        chk("win6_best", int'(best_time), BEST_ON ? 6 : 0);
        play(3, 8, 4'b0100, k);
        chk("win8_best", int'(best_time), BEST_ON ? 6 : 0);

        // rand=2 gives a 5-tick delay; player 2 answers after 7 ticks.
        play(2, 7, 4'b0100, k);
        chk("go_latency", k, 5 * DIV);
        chk("t1_mode", int'(mode), 3);
        chk("t1_number", int'(number), 7);
        chk("t1_winner", int'(winner), 2);
        chk("t1_vld", int'(winner_vld), 1);
        chk("t1_best", int'(best_time), BEST_ON ? 6 : 0);

        // Foul during ARMED.
        rand_val = 14'($urandom);
        pulse_start();
        cyc(15);
        pulse_player(4'b0010);
        chk("foul_mode", int'(mode), 3);
        chk("foul_flag", int'(foul), 1);
        chk("foul_winner", int'(winner), 1);
        chk("foul_go_led", int'(go_led), 0);

        // Timeout with no press.
        rand_val = 14'd0;
        pulse_start();
        wait_mode(2, 100, k);
        wait_mode(3, MAX_TIME * DIV + 20, k);
        chk("to_latency", k, MAX_TIME * DIV);
        chk("to_number", int'(number), MAX_TIME);
        chk("to_flag", int'(timeout), 1);
        chk("to_vld", int'(winner_vld), 0);

        // Players 3 and 1 together, landing on the 5th tick.
        rand_val = 14'd1;
        pulse_start();
        wait_mode(2, 100, k);
        cyc(5 * DIV - 2);
        pulse_player(4'b1010);
        chk("tie_winner", int'(winner), 1);
        chk("tie_number", int'(number), 4);

        // Start held through reset release must not start a game.
        btn_start = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        cyc(2); rst = 1'b1;
        cyc(5);
        chk("held_start_mode", int'(mode), 0);
        btn_start = 1'b0;
        cyc(3);
        chk("held_release_mode", int'(mode), 0);

        // Abort from GO.
        rand_val = 14'd0;
        pulse_start();
        wait_mode(2, 100, k);
        cyc(25);
        pulse_start();
        chk("abort_mode", int'(mode), 0);
        chk("abort_number", int'(number), 0);
        chk("abort_go_led", int'(go_led), 0);

        // Asynchronous reset in the middle of GO.
        pulse_start();
        wait_mode(2, 100, k);
        cyc(33);
        chk("pre_rst_number", int'(number), 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_mode", int'(mode), 0);
        chk("arst_number", int'(number), 0);
        chk("arst_go_led", int'(go_led), 0);
        chk("arst_best", int'(best_time), BEST_ON ? MAX_TIME : 0);
        @(negedge clk); rst = 1'b1;
        cyc(2);

        // Random play.
        for (int seg = 0; seg < 16; seg++) begin
            p = int'($urandom_range(400, 20));
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                rand_val = 14'($urandom);
                if ($urandom_range(59, 0) == 0) btn_start = ~btn_start;
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(p - 1, 0) == 0) btn_player[b] = ~btn_player[b];
                end
            end
        end

        cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
